i2c_txn_arbiter: RTL and testbench

- Round-robin scheduler that shares one I2C master engine between N requesters.
- Each requester posts a single-register transaction: slave address, register address, write data and R/W.
- The arbiter grants one requester at a time, launches the master, and supervises completion with a watchdog timeout.
- Returns read data and a status code to the owning requester. Sits between client blocks (sensor pollers, config loaders) and the I2C master.

---
 rtl/i2c_txn_arbiter.sv | 178 +++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin scheduler sharing one I2C master engine between N requesters.
// Latches the winning command, launches the master, and supervises completion with a watchdog.
module i2c_txn_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [7*N-1:0]   req_slave_addr,
    input  logic [8*N-1:0]   req_reg_addr,
    input  logic [8*N-1:0]   req_wdata,
    input  logic [N-1:0]     req_rw,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     rsp_valid,
    output logic [7:0]       rsp_rdata,
    output logic [1:0]       rsp_err,
    output logic             m_start,
    output logic [6:0]       m_slave_addr,
    output logic [7:0]       m_reg_addr,
    output logic [7:0]       m_wdata,
    output logic             m_rw,
    output logic             m_abort,
    input  logic             m_busy,
    input  logic             m_done,
    input  logic             m_nack,
    input  logic [7:0]       m_rdata,
    output logic [1:0]       dbg_state
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [TW-1:0] wdog;
    logic [IW-1:0] winner;
    logic          found;
    logic [IW:0]   idx_sum;
    logic [IW-1:0] idx;
    logic [IW-1:0] next_ptr;
    logic          take;
    logic          timeout_hit;

    logic [6:0] sa_arr [N];
    logic [7:0] ra_arr [N];
    logic [7:0] wd_arr [N];
    logic       rw_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign sa_arr[g] = req_slave_addr[7*g +: 7];
        assign ra_arr[g] = req_reg_addr[8*g +: 8];
        assign wd_arr[g] = req_wdata[8*g +: 8];
        assign rw_arr[g] = req_rw[g];
    end

    // First asserted request at or above rr_ptr, wrapping modulo N.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idx_sum = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (idx_sum >= (IW+1)'(N)) begin
                idx_sum = idx_sum - (IW+1)'(N);
            end
            idx = idx_sum[IW-1:0];
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign next_ptr    = (winner == IW'(N-1)) ? '0 : winner + 1'b1;
    assign timeout_hit = (wdog == TW'(TIMEOUT-1));
    assign dbg_state   = state;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        gnt       = '0;
        rsp_valid = '0;
        m_start   = 1'b0;
        m_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (found && !m_busy) begin
                    take      = 1'b1;
                    gnt       = N'(1) << winner;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                m_start   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A completion on the timeout cycle wins over the abort.
                if (m_done) begin
                    state_nxt = RESP;
                end else if (timeout_hit) begin
                    m_abort   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = N'(1) << owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            take      = 1'b0;
            gnt       = '0;
            rsp_valid = '0;
            m_start   = 1'b0;
            m_abort   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            wdog         <= '0;
            m_slave_addr <= '0;
            m_reg_addr   <= '0;
            m_wdata      <= '0;
            m_rw         <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                m_slave_addr <= sa_arr[winner];
                m_reg_addr   <= ra_arr[winner];
                m_wdata      <= wd_arr[winner];
                m_rw         <= rw_arr[winner];
                owner        <= winner;
                rr_ptr       <= next_ptr;
            end
            if (state == ISSUE) begin
                wdog <= '0;
            end else if (state == WAIT) begin
                wdog <= wdog + 1'b1;
            end
            if (state == WAIT) begin
                if (m_done) begin
                    rsp_rdata <= m_rw ? m_rdata : 8'h00;
                    rsp_err   <= m_nack ? 2'b01 : 2'b00;
                end else if (timeout_hit) begin
                    rsp_rdata <= 8'h00;
                    rsp_err   <= 2'b10;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_rsp_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid));
    a_no_gnt_busy: assert property (@(posedge clk) disable iff (reset) (gnt != '0) |-> !m_busy);
    a_abort_not_done: assert property (@(posedge clk) disable iff (reset) m_abort |-> !m_done);
`endif

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomized bench for i2c_txn_arbiter: behavioural master model, round-robin reference
// and a response scoreboard; directed cases for write/read/NACK/timeout/busy/reset.
module tb_i2c_txn_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam int TW      = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [7*N-1:0] req_slave_addr;
    logic [8*N-1:0] req_reg_addr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   req_rw;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_rdata;
    logic [1:0]     rsp_err;
    logic           m_start;
    logic [6:0]     m_slave_addr;
    logic [7:0]     m_reg_addr;
    logic [7:0]     m_wdata;
    logic           m_rw;
    logic           m_abort;
    logic           m_busy;
    logic           m_done;
    logic           m_nack;
    logic [7:0]     m_rdata;
    logic [1:0]     dbg_state;

    logic [6:0] sa_t [N];
    logic [7:0] ra_t [N];
    logic [7:0] wd_t [N];
    logic       rw_t [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_slave_addr[7*g +: 7] = sa_t[g];
        assign req_reg_addr[8*g +: 8]   = ra_t[g];
        assign req_wdata[8*g +: 8]      = wd_t[g];
        assign req_rw[g]                = rw_t[g];
    end

    i2c_txn_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_slave_addr(req_slave_addr), .req_reg_addr(req_reg_addr),
        .req_wdata(req_wdata), .req_rw(req_rw),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_start(m_start), .m_slave_addr(m_slave_addr), .m_reg_addr(m_reg_addr),
        .m_wdata(m_wdata), .m_rw(m_rw), .m_abort(m_abort), .m_busy(m_busy),
        .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata), .dbg_state(dbg_state)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: {owner[2:0], err[1:0], rdata[7:0]}
    logic [12:0] exp_q[$];
    int          exp_cyc_q[$];
    int          gnt_log[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          rr_m = 0;
    int          exp_owner = 0;
    logic [6:0]  exp_sa;
    logic [7:0]  exp_ra;
    logic [7:0]  exp_wd;
    logic        exp_rw = 1'b0;
    int          gnt_cyc = -10;
    int          last_start = -100;
    int          exp_abort_cyc = -1;
    bit          inflight = 1'b0;
    int          w;
    logic [12:0] e;
    int          ec;

    // master model configuration
    int          cfg_delay = 5;
    bit          cfg_nack = 1'b0;
    logic [7:0]  cfg_rdata = 8'h00;
    bit          cfg_random = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference: rotate the request vector by the pointer and take the lowest set bit.
    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        logic [2*N-1:0] dbl;
        dbl = {r, r} >> ptr;
        for (int k = 0; k < N; k++) begin
            if (dbl[k]) return (ptr + k) % N;
        end
        return N;
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (gnt != '0) begin
                w = rr_pick(req, rr_m);
                check("gnt_winner", 32'(gnt), 32'(1) << w);
                if (w < N) begin
                    exp_owner = w;
                    exp_sa    = sa_t[w];
                    exp_ra    = ra_t[w];
                    exp_wd    = wd_t[w];
                    exp_rw    = rw_t[w];
                    rr_m      = (w + 1) % N;
                    gnt_log.push_back(w);
                end
                gnt_cyc  = cyc;
                inflight = 1'b1;
            end
            if (m_start) begin
                check("start_latency", 32'(cyc), 32'(gnt_cyc + 1));
                check("start_spacing", 32'(cyc - last_start >= 4), 32'd1);
                check("cmd_slave", 32'(m_slave_addr), 32'(exp_sa));
                check("cmd_reg", 32'(m_reg_addr), 32'(exp_ra));
                check("cmd_wdata", 32'(m_wdata), 32'(exp_wd));
                check("cmd_rw", 32'(m_rw), 32'(exp_rw));
                last_start = cyc;
            end
            if (m_abort) begin
                check("abort_cycle", 32'(cyc), 32'(exp_abort_cyc));
                exp_abort_cyc = -1;
            end
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("rsp_owner", 32'(rsp_valid), 32'(1) << e[12:10]);
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
                    check("rsp_err", 32'(rsp_err), 32'(e[9:8]));
                    check("rsp_cycle", 32'(cyc), 32'(ec));
                    check("abort_missing", 32'(exp_abort_cyc), 32'hFFFF_FFFF);
                end
                inflight = 1'b0;
            end
        end
    end

    // behavioural I2C master: delay 0 means never completes
    initial begin : master_model
        int ms, md;
        bit mn;
        logic [7:0] mr;
        m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00; m_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (m_start && !reset) begin
                ms = cyc;
                if (cfg_random) begin
                    md = $urandom_range(0, TIMEOUT);
                    mn = 1'($urandom_range(0, 1));
                    mr = 8'($urandom);
                end else begin
                    md = cfg_delay; mn = cfg_nack; mr = cfg_rdata;
                end
                if (md == 0) begin
                    exp_q.push_back({3'(exp_owner), 2'b10, 8'h00});
                    exp_cyc_q.push_back(ms + TIMEOUT + 1);
                    exp_abort_cyc = ms + TIMEOUT;
                end else begin
                    exp_q.push_back({3'(exp_owner), 1'b0, mn, exp_rw ? mr : 8'h00});
                    exp_cyc_q.push_back(ms + md + 1);
                end
                @(posedge clk); #1;
                m_busy = 1'b1;
                if (md == 0) begin
                    for (int k = 0; k < TIMEOUT + 8; k++) begin
                        @(negedge clk);
                        if (m_abort) break;
                    end
                    @(posedge clk); #1;
                    m_busy = 1'b0;
                end else begin
                    repeat (md - 1) @(posedge clk);
                    #1;
                    m_done = 1'b1; m_nack = mn; m_rdata = mr;
                    @(posedge clk); #1;
                    m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'($urandom); m_busy = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic wait_gnt(input logic [N-1:0] mask);
        logic [N-1:0] pend, g;
        pend = mask;
        for (int k = 0; k < 800 && pend != '0; k++) begin
            @(negedge clk);
            g = gnt & pend;
            @(posedge clk); #1;
            req  = req & ~g;
            pend = pend & ~g;
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    sa_t[i] = 7'($urandom); ra_t[i] = 8'($urandom);
                    wd_t[i] = 8'($urandom); rw_t[i] = 1'($urandom);
                end
            end
        end
        if (pend != '0) begin
            check("gnt_timeout", 32'(pend), 32'd0);
            req = req & ~pend;
        end
    endtask

    task automatic post_one(input int i, input logic [6:0] sa, input logic [7:0] ra,
                            input logic [7:0] wd, input logic rw);
        @(posedge clk); #1;
        sa_t[i] = sa; ra_t[i] = ra; wd_t[i] = wd; rw_t[i] = rw;
        req[i] = 1'b1;
        wait_gnt(N'(1) << i);
    endtask

    task automatic post_rand(input logic [N-1:0] mask);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                sa_t[i] = 7'($urandom); ra_t[i] = 8'($urandom);
                wd_t[i] = 8'($urandom); rw_t[i] = 1'($urandom);
            end
        end
        req = req | mask;
        wait_gnt(mask);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!inflight && exp_q.size() == 0 && !m_busy) break;
        end
        if (k == 300) check("drain_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req = '0;
        exp_q.delete(); exp_cyc_q.delete();
        rr_m = 0; inflight = 1'b0; exp_abort_cyc = -1; last_start = -100;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_m_start"}, 32'(m_start), 32'd0);
        check({tag, "_m_abort"}, 32'(m_abort), 32'd0);
        check({tag, "_m_cmd"}, {8'h00, m_rw, m_slave_addr, m_reg_addr, m_wdata}, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin : guard
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        reset = 1'b1; req = '0;
        for (int i = 0; i < N; i++) begin
            sa_t[i] = 7'h00; ra_t[i] = 8'h00; wd_t[i] = 8'h00; rw_t[i] = 1'b0;
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // single write; m_rdata non-zero to confirm writes return 0x00
        cfg_delay = 12; cfg_rdata = 8'hEE; cfg_nack = 1'b0;
        post_one(0, 7'h50, 8'h10, 8'hA5, 1'b0);
        drain();

        // read returns data
        cfg_delay = 5; cfg_rdata = 8'h3C;
        post_one(2, 7'h21, 8'h05, 8'h00, 1'b1);
        drain();
        check("rdata_hold", 32'(rsp_rdata), 32'h3C);

        // NACK
        cfg_delay = 3; cfg_nack = 1'b1; cfg_rdata = 8'h99;
        post_one(1, 7'h33, 8'h44, 8'h55, 1'b0);
        drain();
        check("nack_err_hold", 32'(rsp_err), 32'd1);
        cfg_nack = 1'b0;

        // round robin with all requests held
        do_reset();
        gnt_log.delete();
        cfg_delay = 2;
        for (int i = 0; i < N; i++) begin
            sa_t[i] = 7'(8'h10 + i); ra_t[i] = 8'(i * 3); wd_t[i] = 8'(8'hC0 + i); rw_t[i] = 1'b0;
        end
        req = '1;
        for (int k = 0; k < 400 && gnt_log.size() < 5; k++) @(negedge clk);
        @(posedge clk); #1;
        req = '0;
        check("rr_count", 32'(gnt_log.size()), 32'd5);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++) begin
            check("rr_order", 32'(gnt_log[k]), 32'(k % N));
        end
        drain();

        // timeout, recovery, then completion on the timeout cycle
        cfg_delay = 0;
        post_one(3, 7'h7F, 8'hFF, 8'h01, 1'b0);
        drain();
        check("timeout_err_hold", 32'(rsp_err), 32'd2);
        cfg_delay = 4; cfg_rdata = 8'h81;
        post_one(0, 7'h12, 8'h34, 8'h56, 1'b1);
        drain();
        cfg_delay = TIMEOUT; cfg_rdata = 8'h5A;
        post_one(2, 7'h2A, 8'h2B, 8'h2C, 1'b1);
        drain();

        // m_busy blocks grants
        @(posedge clk); #1;
        m_busy = 1'b1;
        sa_t[1] = 7'h61; ra_t[1] = 8'h62; wd_t[1] = 8'h63; rw_t[1] = 1'b0;
        req[1] = 1'b1;
        cfg_delay = 3;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("busy_no_gnt", 32'(gnt), 32'd0);
            check("busy_no_start", 32'(m_start), 32'd0);
        end
        @(posedge clk); #1;
        m_busy = 1'b0;
        @(negedge clk);
        check("gnt_after_busy", 32'(gnt), 32'b0010);
        @(posedge clk); #1;
        req[1] = 1'b0;
        drain();

        // reset while the master is mid-transaction
        cfg_delay = 3; cfg_nack = 1'b1; cfg_rdata = 8'h77;
        post_one(2, 7'h01, 8'h02, 8'h03, 1'b1);
        drain();
        cfg_nack = 1'b0; cfg_delay = 10;
        post_one(1, 7'h0A, 8'h0B, 8'h0C, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_reset_wait", 32'(dbg_state), 32'd2);
        do_reset();
        @(negedge clk);
        check_outputs_zero("midreset");
        post_rand(4'b1001);
        drain();

        // randomized traffic
        cfg_random = 1'b1;
        for (int t = 0; t < 30; t++) begin
            post_rand(N'($urandom_range(1, (1 << N) - 1)));
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
